// File: rtl/uart_sim_pkg.sv
// Shared types for the simulation UART receiver: FSM states and bit-period math.
// Combinational helpers only; no latency, no backpressure.
package uart_sim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_e;

   function automatic int calc_cpb(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, reset to RST_VAL.
// Latency 2 cycles; no backpressure.
module bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ff_q <= {2{RST_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver watching a serial line; strobes each byte and optionally echoes it.
// Strobe lands 2+HALF+9*CPB edges after the start bit is first sampled; no backpressure.
module uart_rx_monitor
   import uart_sim_pkg::*;
#(
   parameter int FREQ  = 27000000,
   parameter int BAUD  = 115200,
   parameter int PRINT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        uart_tx_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   output logic        frame_err_o,
   output logic        busy_o,
   output logic [15:0] rx_count_o
);

   localparam int CPB  = calc_cpb(FREQ, BAUD);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   if (CPB < 4) begin : g_cpb_check
      $fatal(1, "uart_rx_monitor: FREQ/BAUD must be at least 4");
   end

   logic          rx_s;
   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          frame_err_q;
   logic [15:0]   rx_count_q;

   bit_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (uart_tx_i),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         rx_count_q  <= '0;
      end else begin
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end
            START: begin
               // Re-check at mid start bit so a short glitch is dropped silently.
               if (cnt_q == CW'(HALF - 1)) begin
                  if (!rx_s) begin
                     state_q   <= DATA;
                     cnt_q     <= '0;
                     bit_idx_q <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == CW'(CPB - 1)) begin
                  shift_q   <= {rx_s, shift_q[7:1]};
                  cnt_q     <= '0;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (cnt_q == CW'(CPB - 1)) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     data_q     <= shift_q;
                     valid_q    <= 1'b1;
                     rx_count_q <= rx_count_q + 16'd1;
                     state_q    <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            BREAK: begin
               // A held-low line must go high before a new start bit is accepted.
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q != IDLE);
   assign rx_count_o  = rx_count_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (PRINT != 0 && valid_q) begin
         $write("%c", data_q);
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized bench for uart_rx_monitor: drives 8N1 frames and checks strobes against a frame-level model.
// Expected events are queued per transmitted frame with their due cycle; a monitor pops them.
module tb_uart_rx_monitor;

   localparam int FREQ = 460800;
   localparam int BAUD = 115200;
   localparam int CPB  = FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 2 + HALF + 9 * CPB;

   typedef struct {
      bit          err;
      logic [7:0]  dat;
      int          cyc;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        uart_tx_i = 1'b1;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        frame_err_o;
   logic        busy_o;
   logic [15:0] rx_count_o;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   exp_t        expq[$];
   exp_t        got_e;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_last = '0;

   uart_rx_monitor #(
      .FREQ  (FREQ),
      .BAUD  (BAUD),
      .PRINT (1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .uart_tx_i   (uart_tx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .frame_err_o (frame_err_o),
      .busy_o      (busy_o),
      .rx_count_o  (rx_count_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("\nFAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called 1 time unit after a rising edge, so the start bit is first sampled at cyc+1.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit expect_it);
      exp_t e;
      if (expect_it) begin
         e.cyc = cyc + 1 + LAT;
         if (stop_b) begin
            m_cnt  = m_cnt + 16'd1;
            m_last = b;
            e.err  = 1'b0;
         end else begin
            e.err  = 1'b1;
         end
         e.dat = m_last;
         e.cnt = m_cnt;
         expq.push_back(e);
      end
      uart_tx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_tx_i = b[i];
         tick(CPB);
      end
      uart_tx_i = stop_b;
      tick(CPB);
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      uart_tx_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
      m_cnt  = '0;
      m_last = '0;
      tick(4);
   endtask

   always @(negedge clk) begin
      if (!rst_i && (valid_o || frame_err_o)) begin
         chk("strobe_exclusive", {31'd0, valid_o & frame_err_o}, 32'd0);
         if (expq.size() == 0) begin
            chk("unexpected_strobe", {30'd0, valid_o, frame_err_o}, 32'd0);
         end else begin
            got_e = expq.pop_front();
            chk("strobe_kind", {31'd0, frame_err_o}, {31'd0, got_e.err});
            chk("strobe_cycle", cyc, got_e.cyc);
            chk("strobe_data", {24'd0, data_o}, {24'd0, got_e.dat});
            chk("strobe_count", {16'd0, rx_count_o}, {16'd0, got_e.cnt});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("\nFAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int hi;
      logic [7:0] b33;
      logic [7:0] msg [3];

      tick(3);
      chk("rst_data", {24'd0, data_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_count", {16'd0, rx_count_o}, 32'd0);
      rst_i = 1'b0;
      tick(5);

      send_frame(8'h55, 1'b1, 1);
      tick(10);

      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      send_frame(8'hA5, 1'b1, 1);
      tick(10);
      chk("b2b_count", {16'd0, rx_count_o}, 32'd4);

      uart_tx_i = 1'b0;
      tick(1);
      uart_tx_i = 1'b1;
      hi = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy_o) hi++;
         tick(1);
      end
      chk("glitch_busy_bounded", {31'd0, (hi >= 1 && hi <= HALF + 2)}, 32'd1);
      chk("glitch_busy_idle", {31'd0, busy_o}, 32'd0);

      send_frame(8'h41, 1'b0, 1);
      uart_tx_i = 1'b0;
      tick(20);
      chk("break_busy", {31'd0, busy_o}, 32'd1);
      uart_tx_i = 1'b1;
      tick(10);
      send_frame(8'h42, 1'b1, 1);
      tick(10);

      for (int f = 0; f < 30; f++) begin
         b = 8'($urandom_range(0, 255));
         if (b >= 8'h41 && b <= 8'h5A) b = b ^ 8'h20;
         send_frame(b, 1'b1, 1);
         uart_tx_i = 1'b1;
         tick($urandom_range(0, 6));
      end
      tick(LAT + 10);
      chk("random_pending", expq.size(), 32'd0);

      b33 = 8'h33;
      uart_tx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         uart_tx_i = b33[i];
         tick(CPB);
      end
      uart_tx_i = b33[3];
      tick(2);
      rst_i = 1'b1;
      uart_tx_i = 1'b1;
      tick(2);
      chk("midrst_data", {24'd0, data_o}, 32'd0);
      chk("midrst_valid", {31'd0, valid_o}, 32'd0);
      chk("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);
      chk("midrst_count", {16'd0, rx_count_o}, 32'd0);
      rst_i = 1'b0;
      m_cnt  = '0;
      m_last = '0;
      tick(3 * LAT);
      send_frame(8'h34, 1'b1, 1);
      tick(10);

      pulse_reset();
      msg[0] = 8'h48;
      msg[1] = 8'h69;
      msg[2] = 8'h0A;
      for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1, 1);
      tick(20);
      chk("print_count", {16'd0, rx_count_o}, 32'd3);
      chk("final_pending", expq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
